// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and types for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

  // Default widths and latency of the FIFO read port this reader attaches to.
  localparam int FSR_FIFO_WIDTH = 16;
  localparam int FSR_CNT_WIDTH  = 16;
  localparam int FSR_RD_LATENCY = 1;

  // Output buffer depth and the width needed to count 0..SKID_DEPTH.
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  // True when one more pop still has guaranteed room in the buffer once
  // everything already requested has landed and this cycle's handshake leaves.
  function automatic logic credit_ok(input logic [OCC_W-1:0] occ,
                                     input int               inflight,
                                     input logic             pop);
    return (int'(occ) + inflight - int'(pop)) < SKID_DEPTH;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port and downstream stream signals of the reader, bundled together.
interface fifo_stream_reader_if #(
  parameter int W = 16
) ();

  logic         fifo_empty;
  logic [W-1:0] fifo_data_out;
  logic         fifo_underflow;
  logic         fifo_rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;

  // Reader side: pops the FIFO and sources the stream.
  modport master (
    output fifo_rd_en, m_valid, m_data,
    input  fifo_empty, fifo_data_out, fifo_underflow, m_ready
  );

  // Environment side: the FIFO plus the downstream consumer.
  modport slave (
    input  fifo_rd_en, m_valid, m_data,
    output fifo_empty, fifo_data_out, fifo_underflow, m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Small in-order output buffer for a valid/ready stream. Head entry and
// occupancy are flops, so valid/data leave the block straight from registers.
module stream_skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OCC_W-1:0] occ,
  output logic             valid
);

  localparam int             IDX_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(SKID_DEPTH);

  logic [WIDTH-1:0] entry_q [SKID_DEPTH];
  logic [WIDTH-1:0] entry_d [SKID_DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] wr_pos;
  logic             do_pop, do_push;

  // A pop needs a word; a push needs room, which a same-cycle pop provides.
  assign do_pop  = pop & (occ_q != '0);
  assign do_push = push & ((occ_q != FULL) | do_pop);
  assign wr_pos  = occ_q - OCC_W'(do_pop);

  // Next contents: shift toward the head on pop, then append at the tail.
  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    if (do_pop) begin
      for (int i = 0; i < SKID_DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i + 1];
      end
    end
    if (do_push) begin
      entry_d[wr_pos[IDX_W-1:0]] = push_data;
    end
    occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign head  = entry_q[0];
  assign occ   = occ_q;
  assign valid = (occ_q != '0);

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and re-presents its words on a valid/ready stream.
// Pops are credit-limited so every requested word has a buffer slot when it
// returns; underflow-flagged returns are discarded and counted.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = FSR_FIFO_WIDTH,
  parameter int RD_LATENCY = FSR_RD_LATENCY,
  parameter int CNT_WIDTH  = FSR_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  reader_state_e         state_q;
  logic                  busy_q;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  pop_count_q, pop_count_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic [OCC_W-1:0]      occ;
  logic                  skid_valid;
  logic [FIFO_WIDTH-1:0] skid_head;
  logic                  pop_now, ret_valid, ret_push, ret_drop, rd_en;
  int                    inflight_cnt, occ_after;

  assign pop_now   = skid_valid & bus.m_ready;
  assign ret_valid = inflight_q[RD_LATENCY-1];
  assign ret_push  = ret_valid & ~bus.fifo_underflow;
  assign ret_drop  = ret_valid & bus.fifo_underflow;

  // Number of pops still waiting for their return.
  always_comb begin
    inflight_cnt = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_cnt += int'(inflight_q[i]);
    end
  end

  // Pop request: running, FIFO not empty, and a slot is guaranteed on return.
  always_comb begin
    rd_en = (state_q == RUN) & ~bus.fifo_empty & credit_ok(occ, inflight_cnt, pop_now);
  end

  // Next in-flight pipe and buffer occupancy after this cycle's push/pop.
  always_comb begin
    inflight_d = (inflight_q << 1) | RD_LATENCY'(rd_en);
    occ_after  = int'(occ) + int'(ret_push) - int'(pop_now);
  end

  // Status counters: popped words wrap, dropped returns saturate.
  always_comb begin
    pop_count_d  = pop_count_q + CNT_WIDTH'(ret_push);
    drop_count_d = drop_count_q;
    if (ret_drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end
  end

  // In-flight pipe and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= '0;
      pop_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      inflight_q   <= inflight_d;
      pop_count_q  <= pop_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Run/drain control; DRAIN returns to IDLE on the same edge that empties the
  // buffer, so busy drops the cycle after the final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (en) begin
            state_q <= RUN;
          end else if ((occ_after == 0) && (inflight_d == '0)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  stream_skid_buffer #(
    .WIDTH(FIFO_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (ret_push),
    .push_data (bus.fifo_data_out),
    .pop       (pop_now),
    .head      (skid_head),
    .occ       (occ),
    .valid     (skid_valid)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = skid_valid;
  assign bus.m_data     = skid_head;
  assign busy           = busy_q;
  assign pop_count      = pop_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the reader and
// a queue scoreboard checks stream order, counters and pop credit.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          busy;
  logic [CW-1:0] pop_count, drop_count;

  fifo_stream_reader_if #(.W(W)) bus ();

  fifo_stream_reader #(
    .FIFO_WIDTH(W),
    .RD_LATENCY(1),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .pop_count (pop_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO + stream environment model
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           buf_cnt, infl, ret_good, pop_exp, drop_exp;
  int           wr_pct, rdy_pct;
  logic         fake_ne;
  logic [W-1:0] next_word;

  // per-cycle observations
  logic         obs_rd, obs_valid, obs_ready, obs_busy, obs_empty, obs_pop, obs_exp_ok;
  logic [W-1:0] obs_data, obs_exp;
  logic [CW-1:0] obs_pc, obs_dc;
  int           obs_buf, obs_infl, obs_pop_exp, obs_drop_exp;

  // One clock: sample at negedge, then advance the environment after posedge.
  task automatic step();
    logic r;
    logic [W-1:0] w;
    @(negedge clk);
    r          = rst;
    obs_rd     = bus.fifo_rd_en;
    obs_valid  = bus.m_valid;
    obs_ready  = bus.m_ready;
    obs_data   = bus.m_data;
    obs_busy   = busy;
    obs_empty  = bus.fifo_empty;
    obs_pc     = pop_count;
    obs_dc     = drop_count;
    obs_pop    = obs_valid & obs_ready;
    obs_buf    = buf_cnt;
    obs_infl   = infl;
    obs_pop_exp  = pop_exp;
    obs_drop_exp = drop_exp;
    obs_exp_ok = 1'b0;
    obs_exp    = '0;
    if (obs_pop && buf_cnt > 0 && exp_q.size() > 0) begin
      obs_exp    = exp_q.pop_front();
      obs_exp_ok = 1'b1;
      buf_cnt--;
    end
    @(posedge clk);
    #1;
    if (r) begin
      buf_cnt  = 0;
      infl     = 0;
      ret_good = 0;
      pop_exp  = 0;
      drop_exp = 0;
      exp_q.delete();
      if (obs_rd && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
      end
    end else begin
      if (infl != 0) begin
        if (ret_good != 0) begin
          buf_cnt++;
          pop_exp++;
        end else if (drop_exp < 65535) begin
          drop_exp++;
        end
      end
      infl = obs_rd ? 1 : 0;
      if (obs_rd) begin
        if (fifo_q.size() == 0) begin
          bus.fifo_data_out  = 16'hDEAD;
          bus.fifo_underflow = 1'b1;
          ret_good = 0;
        end else begin
          w = fifo_q.pop_front();
          bus.fifo_data_out  = w;
          bus.fifo_underflow = 1'b0;
          ret_good = 1;
          exp_q.push_back(w);
        end
      end
    end
    if (wr_pct > 0 && $urandom_range(99) < wr_pct && fifo_q.size() < 32) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 16'd1;
    end
    bus.fifo_empty = (fifo_q.size() == 0) && !fake_ne;
    bus.m_ready    = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
    fifo_q.delete();
    bus.fifo_empty = 1'b1;
  endtask

  task automatic load_fifo(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + W'(i));
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", obs_valid); end
    n_checks++; if (obs_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0000", obs_data); end
    n_checks++; if (obs_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", obs_rd); end
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
    n_checks++; if (obs_pc !== 16'h0) begin n_fail++; $display("FAIL reset_pop_count: got %0d want 0", obs_pc); end
    n_checks++; if (obs_dc !== 16'h0) begin n_fail++; $display("FAIL reset_drop_count: got %0d want 0", obs_dc); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int rd_cyc[$];
    int hs_cyc[$];
    logic [W-1:0] hs_dat[$];
    int a, b;
    do_reset();
    load_fifo(16'h0001, 4);
    wr_pct = 0; rdy_pct = 100; bus.m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (obs_rd) rd_cyc.push_back(i);
      if (obs_pop) begin hs_cyc.push_back(i); hs_dat.push_back(obs_data); end
    end
    n_checks++; if (rd_cyc.size() != 4) begin n_fail++; $display("FAIL basic_rd_pulses: got %0d want 4", rd_cyc.size()); end
    a = (rd_cyc.size() == 4) ? rd_cyc[3] - rd_cyc[0] : -1;
    n_checks++; if (a != 3) begin n_fail++; $display("FAIL basic_rd_consecutive: span %0d want 3", a); end
    n_checks++; if (hs_cyc.size() != 4) begin n_fail++; $display("FAIL basic_handshakes: got %0d want 4", hs_cyc.size()); end
    a = (hs_cyc.size() > 0 && rd_cyc.size() > 0) ? hs_cyc[0] - rd_cyc[0] : -1;
    n_checks++; if (a != 2) begin n_fail++; $display("FAIL basic_first_latency: got %0d want 2", a); end
    b = (hs_cyc.size() == 4) ? hs_cyc[3] - hs_cyc[0] : -1;
    n_checks++; if (b != 3) begin n_fail++; $display("FAIL basic_hs_consecutive: span %0d want 3", b); end
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] got;
      got = (i < hs_dat.size()) ? hs_dat[i] : 16'hXXXX;
      n_checks++; if (got !== W'(i + 1)) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, got, W'(i + 1)); end
    end
    n_checks++; if (obs_pc !== 16'd4) begin n_fail++; $display("FAIL basic_pop_count: got %0d want 4", obs_pc); end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    int rd_n = 0;
    int k = 0;
    do_reset();
    load_fifo(16'h0010, 8);
    wr_pct = 0; rdy_pct = 0; bus.m_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_rd) rd_n++;
      if (i >= 5) begin
        n_checks++; if (obs_valid !== 1'b1 || obs_data !== 16'h0010) begin n_fail++; $display("FAIL bp_hold cyc %0d: got v=%b d=%h want v=1 d=0010", i, obs_valid, obs_data); end
      end
    end
    n_checks++; if (rd_n != 2) begin n_fail++; $display("FAIL bp_rd_pulses: got %0d want 2", rd_n); end
    n_checks++; if (obs_pc !== 16'd2) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 2", obs_pc); end
    rdy_pct = 100; bus.m_ready = 1'b1;
    for (int i = 0; i < 40 && k < 8; i++) begin
      step();
      if (obs_rd) rd_n++;
      if (obs_pop) begin
        n_checks++; if (obs_data !== 16'h0010 + W'(k)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", k, obs_data, 16'h0010 + W'(k)); end
        k++;
      end
    end
    n_checks++; if (k != 8) begin n_fail++; $display("FAIL bp_words_received: got %0d want 8", k); end
    n_checks++; if (rd_n != 8) begin n_fail++; $display("FAIL bp_total_rd: got %0d want 8", rd_n); end
    en = 1'b0; step(); step();
    $display("test_backpressure done");
  endtask

  task automatic test_underflow();
    logic saw_valid = 1'b0;
    logic saw_dead = 1'b0;
    int k = 0;
    do_reset();
    wr_pct = 0; rdy_pct = 100; bus.m_ready = 1'b1; en = 1'b1;
    step(); step(); step();
    fake_ne = 1'b1; bus.fifo_empty = 1'b0;
    step();
    fake_ne = 1'b0; bus.fifo_empty = 1'b1;
    n_checks++; if (obs_rd !== 1'b1) begin n_fail++; $display("FAIL uf_rd_on_lagging_empty: got %b want 1", obs_rd); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_valid) saw_valid = 1'b1;
      if (obs_valid && obs_data == 16'hDEAD) saw_dead = 1'b1;
    end
    n_checks++; if (saw_valid !== 1'b0 || saw_dead !== 1'b0) begin n_fail++; $display("FAIL uf_word_leaked: valid=%b dead=%b want 0 0", saw_valid, saw_dead); end
    n_checks++; if (obs_dc !== 16'd1) begin n_fail++; $display("FAIL uf_drop_count: got %0d want 1", obs_dc); end
    n_checks++; if (obs_pc !== 16'd0) begin n_fail++; $display("FAIL uf_pop_count: got %0d want 0", obs_pc); end
    load_fifo(16'h0042, 1);
    for (int i = 0; i < 10 && k == 0; i++) begin
      step();
      if (obs_pop) begin
        k++;
        n_checks++; if (obs_data !== 16'h0042) begin n_fail++; $display("FAIL uf_next_word: got %h want 0042", obs_data); end
      end
    end
    n_checks++; if (k != 1) begin n_fail++; $display("FAIL uf_next_word_seen: got %0d want 1", k); end
    step();
    n_checks++; if (obs_pc !== 16'd1) begin n_fail++; $display("FAIL uf_pop_count_after: got %0d want 1", obs_pc); end
    en = 1'b0; step(); step();
    $display("test_underflow done");
  endtask

  task automatic test_drain();
    int k = 0;
    int late_rd = 0;
    int last_hs = -1;
    logic busy_arr[12];
    do_reset();
    load_fifo(16'h0100, 20);
    wr_pct = 0; rdy_pct = 100; bus.m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_pop) begin
        n_checks++; if (obs_data !== 16'h0100 + W'(k)) begin n_fail++; $display("FAIL drain_run_order[%0d]: got %h want %h", k, obs_data, 16'h0100 + W'(k)); end
        k++;
      end
    end
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      busy_arr[i] = obs_busy;
      if (i >= 1 && obs_rd) late_rd++;
      if (obs_pop) begin
        n_checks++; if (obs_data !== 16'h0100 + W'(k)) begin n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", k, obs_data, 16'h0100 + W'(k)); end
        k++;
        last_hs = i;
      end
    end
    n_checks++; if (late_rd != 0) begin n_fail++; $display("FAIL drain_rd_after_stop: got %0d pulses want 0", late_rd); end
    n_checks++; if (k != 20 - fifo_q.size()) begin n_fail++; $display("FAIL drain_delivered: got %0d want %0d", k, 20 - fifo_q.size()); end
    n_checks++; if (last_hs < 0 || last_hs > 10 || busy_arr[last_hs] !== 1'b1) begin n_fail++; $display("FAIL drain_busy_at_last_hs: idx %0d want busy 1", last_hs); end
    n_checks++; if (last_hs < 0 || last_hs > 10 || busy_arr[last_hs + 1] !== 1'b0) begin n_fail++; $display("FAIL drain_busy_after_last_hs: idx %0d want busy 0", last_hs); end
    n_checks++; if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got v=%b busy=%b want 0 0", obs_valid, obs_busy); end
    $display("test_drain done");
  endtask

  task automatic test_reset_midflight();
    logic saw_valid = 1'b0;
    logic [W-1:0] want;
    int k = 0;
    do_reset();
    load_fifo(16'h0200, 10);
    wr_pct = 0; rdy_pct = 100; bus.m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid: got %b want 0", obs_valid); end
    n_checks++; if (obs_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b want 0", obs_rd); end
    n_checks++; if (obs_pc !== 16'd0 || obs_dc !== 16'd0) begin n_fail++; $display("FAIL rstmid_counters: got %0d/%0d want 0/0", obs_pc, obs_dc); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_valid) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_lost_word_delivered: got valid=1 want 0"); end
    want = fifo_q[0];
    en = 1'b1;
    for (int i = 0; i < 10 && k == 0; i++) begin
      step();
      if (obs_pop) begin
        k++;
        n_checks++; if (obs_data !== want) begin n_fail++; $display("FAIL rstmid_restart_word: got %h want %h", obs_data, want); end
      end
    end
    n_checks++; if (k != 1) begin n_fail++; $display("FAIL rstmid_restart_seen: got %0d want 1", k); end
    $display("test_reset_midflight done");
  endtask

  task automatic test_random();
    int wr_tab[3];
    int rd_tab[3];
    int recv = 0;
    int guard = 0;
    wr_tab = '{80, 20, 50};
    rd_tab = '{20, 80, 50};
    do_reset();
    next_word = 16'h1000;
    for (int p = 0; p < 3; p++) begin
      wr_pct  = wr_tab[p];
      rdy_pct = rd_tab[p];
      for (int i = 0; i < 1000; i++) begin
        en = ($urandom_range(99) < 97);
        step();
        n_checks++; if (obs_valid !== (obs_buf != 0)) begin n_fail++; $display("FAIL rnd_valid p%0d c%0d: got %b want %b", p, i, obs_valid, obs_buf != 0); end
        if (obs_pop) begin
          recv++;
          n_checks++; if (!obs_exp_ok || obs_data !== obs_exp) begin n_fail++; $display("FAIL rnd_order p%0d c%0d: got %h want %h", p, i, obs_data, obs_exp); end
        end
        n_checks++; if (obs_rd && (obs_buf + obs_infl - int'(obs_pop) >= 2)) begin n_fail++; $display("FAIL rnd_credit p%0d c%0d: rd=1 occ=%0d infl=%0d pop=%b", p, i, obs_buf, obs_infl, obs_pop); end
        n_checks++; if (obs_rd && obs_empty) begin n_fail++; $display("FAIL rnd_rd_when_empty p%0d c%0d: got rd=1 want 0", p, i); end
        n_checks++; if (obs_pc !== obs_pop_exp[CW-1:0]) begin n_fail++; $display("FAIL rnd_pop_count p%0d c%0d: got %0d want %0d", p, i, obs_pc, obs_pop_exp); end
        n_checks++; if (obs_dc !== obs_drop_exp[CW-1:0]) begin n_fail++; $display("FAIL rnd_drop_count p%0d c%0d: got %0d want %0d", p, i, obs_dc, obs_drop_exp); end
      end
    end
    en = 1'b1; wr_pct = 0; rdy_pct = 100;
    while ((exp_q.size() > 0 || fifo_q.size() > 0 || buf_cnt > 0) && guard < 200) begin
      step();
      guard++;
      if (obs_pop) begin
        recv++;
        n_checks++; if (!obs_exp_ok || obs_data !== obs_exp) begin n_fail++; $display("FAIL rnd_flush_order: got %h want %h", obs_data, obs_exp); end
      end
    end
    step(); step();
    n_checks++; if (exp_q.size() != 0 || guard >= 200) begin n_fail++; $display("FAIL rnd_flush: %0d words undelivered after %0d cycles want 0", exp_q.size(), guard); end
    n_checks++; if (obs_pc !== recv[CW-1:0]) begin n_fail++; $display("FAIL rnd_pop_count_final: got %0d want %0d", obs_pc, recv); end
    en = 1'b0; step(); step();
    $display("test_random done: %0d words received", recv);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fake_ne = 1'b0;
    wr_pct = 0; rdy_pct = 100; next_word = 16'h0000;
    buf_cnt = 0; infl = 0; ret_good = 0; pop_exp = 0; drop_exp = 0;
    bus.fifo_empty = 1'b1; bus.fifo_data_out = '0; bus.fifo_underflow = 1'b0; bus.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_underflow();
    test_drain();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
